// File: rtl/led_mode_sel.sv
// LED output stage: debounced key steps through four display modes
// (full breath, running breath, all on, all off) driving six LEDs.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset
//   key_n     - raw active-low push button, asynchronous, bouncy
//   breath_in - breathing waveform, already at pin polarity
//   led       - registered LED pin drive
//   mode      - current display mode (0 BREATH, 1 RUN, 2 ON, 3 OFF)
module led_mode_sel #(
  parameter int unsigned DEBOUNCE_MAX = 540_000,
  parameter int unsigned STEP_MAX     = 13_500_000,
  parameter logic        LED_OFF      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [5:0] breath_in,
  output logic [5:0] led,
  output logic [1:0] mode
);

  localparam int DW =
    (DEBOUNCE_MAX > 1) ? $clog2(DEBOUNCE_MAX) : 1;
  localparam int SW =
    (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_MAX - 1);
  localparam logic [SW-1:0] STEP_LAST =
    SW'(STEP_MAX - 1);

  typedef enum logic [1:0] {
    BREATH = 2'd0,
    RUN    = 2'd1,
    ON     = 2'd2,
    OFF    = 2'd3
  } mode_e;

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic          stable_prev_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          press;

  mode_e         mode_q, mode_d;
  logic [2:0]    idx_q, idx_d;
  logic [SW-1:0] step_q, step_d;
  logic [5:0]    led_q, led_d;

  // two-flop synchronizer, released level on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  // counter only advances while the synced key disagrees
  // with the accepted level; any agreement restarts it
  always_comb begin
    db_cnt_d = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q      <= '0;
      stable_q      <= 1'b1;
      stable_prev_q <= 1'b1;
    end else begin
      db_cnt_q      <= db_cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
    end
  end

  // one pulse per accepted press; releases are ignored
  assign press = stable_prev_q & ~stable_q;

  // a press always wins over a step wrap and clears
  // the running position
  always_comb begin
    mode_d = mode_q;
    idx_d  = '0;
    step_d = '0;
    if (press) begin
      unique case (mode_q)
        BREATH: mode_d = RUN;
        RUN:    mode_d = ON;
        ON:     mode_d = OFF;
        OFF:    mode_d = BREATH;
      endcase
    end else if (mode_q == RUN) begin
      if (step_q == STEP_LAST) begin
        idx_d = (idx_q == 3'd5) ? 3'd0
                                : idx_q + 3'd1;
      end else begin
        idx_d  = idx_q;
        step_d = step_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= BREATH;
      idx_q  <= '0;
      step_q <= '0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    led_d = {6{LED_OFF}};
    unique case (1'b1)
      (mode_q == BREATH): led_d = breath_in;
      (mode_q == RUN):
        led_d[idx_q] = breath_in[idx_q];
      (mode_q == ON):     led_d = {6{~LED_OFF}};
      (mode_q == OFF):    led_d = {6{LED_OFF}};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= {6{LED_OFF}};
    end else begin
      led_q <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_sel.sv
// Self-checking bench for led_mode_sel with a small
// event-level reference model and hand-built corner cases.
module tb_led_mode_sel;

  localparam int DBM = 4;
  localparam int STM = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic [5:0] breath_in;
  logic [5:0] led;
  logic [1:0] mode;

  int n_pass = 0;
  int n_tot  = 0;

  led_mode_sel #(
    .DEBOUNCE_MAX(DBM),
    .STEP_MAX(STM),
    .LED_OFF(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .breath_in(breath_in),
    .led(led),
    .mode(mode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: act=%0h req=%0h t=%0t",
               nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // reference model: mode = presses mod 4,
  // run position from elapsed edges since RUN entry
  int         m_mode;
  int         m_run0;
  int         m_since;
  int         m_edge;
  bit         m_stable;
  bit         m_pend;
  bit         kp0, kp1;
  bit         hist[$];
  logic [5:0] m_led;

  function automatic logic [5:0] led_of(
    input int md, input int ix, input logic [5:0] b);
    logic [5:0] r;
    r = 6'h3f;
    case (md)
      0: r = b;
      1: r[ix] = b[ix];
      2: r = 6'h00;
      default: r = 6'h3f;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run0 = 0; m_since = 0;
    m_edge = 0; m_stable = 1; m_pend = 0;
    kp0 = 1; kp1 = 1; hist.delete();
    m_led = 6'h3f;
  endtask

  task automatic model_edge(input bit k,
                            input logic [5:0] b);
    int ix;
    bit flip;
    ix = (m_mode == 1) ?
         ((m_edge - m_run0) / STM) % 6 : 0;
    m_led = led_of(m_mode, ix, b);
    hist.push_back(kp1);
    if (hist.size() > DBM) void'(hist.pop_front());
    m_since++;
    flip = (m_since >= DBM);
    foreach (hist[i])
      if (hist[i] == m_stable) flip = 0;
    m_edge++;
    if (m_pend) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 1) m_run0 = m_edge;
    end
    m_pend = flip && m_stable;
    if (flip) begin
      m_stable = !m_stable;
      m_since = 0;
    end
    kp1 = kp0;
    kp0 = k;
  endtask

  task automatic cyc(input bit k, input logic [5:0] b);
    key_n = k;
    breath_in = b;
    @(posedge clk);
    model_edge(k, b);
    #1;
    chk("led_model", led, m_led);
    chk("mode_model", mode, m_mode);
  endtask

  task automatic press(input int h, input int r,
                       input logic [5:0] b);
    repeat (h) cyc(1'b0, b);
    repeat (r) cyc(1'b1, b);
  endtask

  task automatic run_entry(input string nm);
    repeat (7) cyc(1'b0, 6'h00);
    chk({nm, "_mode"}, mode, 2'd1);
    cyc(1'b0, 6'h00);
    chk({nm, "_bit0"}, led, 6'h3e);
    repeat (8) cyc(1'b1, 6'h00);
  endtask

  typedef struct {
    bit         key;
    logic [5:0] b;
    logic [5:0] el;
    logic [1:0] em;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int e0, lat, chg, rel, run0;
    logic [1:0] pm;
    logic [5:0] ex;

    tbl[0] = '{1, 6'h2a, 6'h2a, 0};
    tbl[1] = '{1, 6'h15, 6'h15, 0};
    for (int i = 2; i < 18; i++)
      tbl[i] = '{1, 6'h15, 6'h15, 0};
    tbl[2].key = 0; tbl[3].key = 0; tbl[4].key = 0;
    tbl[10].key = 0; tbl[12].key = 0;

    reset = 1'b1;
    key_n = 1'b1;
    breath_in = 6'h2a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", led, 6'h3f);
    chk("rst_mode", mode, 2'd0);
    reset = 1'b0;
    model_reset();

    // reset release, breath follow, glitch and bounce
    foreach (tbl[i]) begin
      key_n = tbl[i].key;
      breath_in = tbl[i].b;
      @(posedge clk);
      model_edge(tbl[i].key, tbl[i].b);
      #1;
      chk($sformatf("tbl%0d_led", i), led, tbl[i].el);
      chk($sformatf("tbl%0d_mode", i), mode, tbl[i].em);
    end

    // press into RUN, key held 50 cycles
    e0 = m_edge; lat = -1; chg = 0; pm = mode;
    for (int i = 0; i < 60; i++) begin
      cyc(i < 50 ? 1'b0 : 1'b1, 6'h00);
      if (mode !== pm) begin
        chg++;
        if (lat < 0) lat = m_edge - e0;
      end
      pm = mode;
      rel = m_edge - (e0 + 7);
      if (rel >= 1 && rel <= 19 &&
          (rel - 1) % 3 == 0) begin
        ex = 6'h3f;
        ex[((rel - 1) / 3) % 6] = 1'b0;
        chk($sformatf("run_pos%0d", rel), led, ex);
      end
    end
    chk("press_latency", lat, 7);
    chk("press_once", chg, 1);

    // remaining mode cycle
    press(8, 8, 6'h15);
    chk("cyc_m2", mode, 2'd2);
    chk("cyc_on", led, 6'h00);
    press(8, 8, 6'h15);
    chk("cyc_m3", mode, 2'd3);
    chk("cyc_off", led, 6'h3f);
    press(8, 8, 6'h2d);
    chk("cyc_m0", mode, 2'd0);
    chk("cyc_breath", led, 6'h2d);
    run_entry("reenter");

    // press lands on the idx 5 -> 0 wrap
    run0 = m_run0;
    while (m_edge < run0 + 11) cyc(1'b1, 6'h00);
    repeat (6) cyc(1'b0, 6'h00);
    chk("coll_idx5", led, 6'h1f);
    cyc(1'b0, 6'h00);
    chk("coll_mode", mode, 2'd2);
    repeat (7) cyc(1'b0, 6'h00);
    repeat (8) cyc(1'b1, 6'h00);
    press(8, 8, 6'h00);
    press(8, 8, 6'h00);
    run_entry("coll_reenter");

    // random key activity and breath data
    for (int i = 0; i < 80; i++) begin
      int len;
      bit k;
      len = $urandom_range(1, 7);
      k = $urandom_range(0, 1);
      repeat (len) cyc(k, 6'($urandom));
    end
    repeat (8) cyc(1'b1, 6'h00);

    // reset mid-RUN while a debounce is counting
    for (int i = 0; i < 4 && m_mode != 1; i++)
      press(8, 8, 6'h00);
    chk("pre_rst_run", mode, 2'd1);
    repeat (3) cyc(1'b0, 6'h00);
    #3;
    reset = 1'b1;
    #1;
    chk("async_led", led, 6'h3f);
    chk("async_mode", mode, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    e0 = m_edge; lat = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 6'h00);
      if (lat < 0 && mode === 2'd1)
        lat = m_edge - e0;
    end
    chk("post_rst_latency", lat, 7);
    repeat (10) cyc(1'b1, 6'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
